// File: rtl/beam_counter.sv
// ---------------------------------------------------------------------------
// beam_counter
//
// Video beam position counter with interlace handling and a light-pen latch.
// H counts colour clocks 0..226 per line. V counts lines up to a last line
// that depends on the line standard and the long-frame flag. Both positions
// can be overwritten by CPU writes, and writes win over counting.
//
// Ports
//   CLK       in   1  system clock, all state on rising edge
//   RST       in   1  synchronous active-high reset
//   CE        in   1  colour-clock enable, beam advances only when high
//   PAL       in   1  1 = PAL (313/312 lines), 0 = NTSC (263/262 lines)
//   LACE      in   1  interlace enable (LOF toggles per frame when high)
//   LP        in   1  light-pen strobe, rising edge significant
//   WR_VHPOS  in   1  load V[7:0] <= DB[15:8], H <= DB[7:0]
//   WR_VPOS   in   1  load LOF <= DB[15], V[8] <= DB[0]
//   DB        in  16  write data bus
//   HPOS      out  8  horizontal beam position
//   VPOS      out  9  vertical beam position
//   LOF       out  1  long-frame flag
//   HSTB      out  1  one-cycle pulse after a line wrap
//   VSTB      out  1  one-cycle pulse after a frame wrap
//   VV        out 15  comparator bus {VPOS[7:0], HPOS[7:1]}
//   LPH       out  8  light-pen horizontal latch
//   LPV       out  9  light-pen vertical latch
// ---------------------------------------------------------------------------
module beam_counter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        PAL,
    input  logic        LACE,
    input  logic        LP,
    input  logic        WR_VHPOS,
    input  logic        WR_VPOS,
    input  logic [15:0] DB,
    output logic [7:0]  HPOS,
    output logic [8:0]  VPOS,
    output logic        LOF,
    output logic        HSTB,
    output logic        VSTB,
    output logic [14:0] VV,
    output logic [7:0]  LPH,
    output logic [8:0]  LPV
);

    localparam logic [7:0] H_LAST = 8'd226;
    localparam logic [7:0] H_MAX  = 8'd255;
    localparam logic [8:0] V_MAX  = 9'd511;

    // Last line number of the current frame. Long frames carry one extra line.
    function automatic logic [8:0] last_line(input logic pal, input logic lof);
        logic [8:0] ll;
        if (pal) begin
            ll = lof ? 9'd312 : 9'd311;
        end else begin
            ll = lof ? 9'd262 : 9'd261;
        end
        return ll;
    endfunction

    // Registered state
    logic [7:0] h_p1;
    logic [8:0] v_p1;
    logic       lof_p1;
    logic       hstb_p1;
    logic       vstb_p1;
    logic [7:0] lph_p1;
    logic [8:0] lpv_p1;
    logic       armed_p1;
    logic       lp_p1;      // LP sampled once
    logic       lp_p2;      // previous sample, for edge detection

    // Next-state decode
    logic       wr_any;
    logic       cnt_en;
    logic       h_wrap;
    logic [7:0] h_next;
    logic [8:0] v_last;
    logic       v_wrap;
    logic [8:0] v_next;
    logic       line_wrap;
    logic       frame_wrap;
    logic       lp_edge;
    logic       lp_capture;

    always_comb begin
        wr_any     = WR_VHPOS | WR_VPOS;
        cnt_en     = CE & ~wr_any;

        // A written H above 226 runs on to 255 and wraps there like a line end.
        h_wrap     = (h_p1 == H_LAST) || (h_p1 == H_MAX);
        h_next     = h_wrap ? 8'd0 : h_p1 + 8'd1;

        // V beyond the last line (after a write or a PAL change) runs on to
        // 511 and wraps modulo 512; that wrap is treated as a frame end too.
        v_last     = last_line(PAL, lof_p1);
        v_wrap     = (v_p1 == v_last) || (v_p1 == V_MAX);
        v_next     = v_wrap ? 9'd0 : v_p1 + 9'd1;

        line_wrap  = cnt_en & h_wrap;
        frame_wrap = line_wrap & v_wrap;

        lp_edge    = lp_p1 & ~lp_p2;
        lp_capture = lp_edge & armed_p1;
    end

    // ---- stage p1: beam state, strobes and light-pen latch ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            h_p1     <= 8'd0;
            v_p1     <= 9'd0;
            lof_p1   <= 1'b1;
            hstb_p1  <= 1'b0;
            vstb_p1  <= 1'b0;
            lph_p1   <= 8'd0;
            lpv_p1   <= 9'd0;
            armed_p1 <= 1'b1;
            lp_p1    <= 1'b0;
            lp_p2    <= 1'b0;
        end else begin
            lp_p1   <= LP;
            lp_p2   <= lp_p1;
            hstb_p1 <= line_wrap;
            vstb_p1 <= frame_wrap;

            if (wr_any) begin
                if (WR_VHPOS) begin
                    h_p1      <= DB[7:0];
                    v_p1[7:0] <= DB[15:8];
                end
                if (WR_VPOS) begin
                    lof_p1    <= DB[15];
                    v_p1[8]   <= DB[0];
                end
            end else if (CE) begin
                h_p1 <= h_next;
                if (h_wrap) begin
                    v_p1 <= v_next;
                end
                if (frame_wrap) begin
                    lof_p1 <= LACE ? ~lof_p1 : 1'b1;
                end
            end

            // Capture uses the pre-update position; a same-cycle frame wrap
            // re-arms, so the latch is ready again for the new frame.
            if (lp_capture) begin
                lph_p1 <= h_p1;
                lpv_p1 <= v_p1;
            end
            if (frame_wrap) begin
                armed_p1 <= 1'b1;
            end else if (lp_capture) begin
                armed_p1 <= 1'b0;
            end
        end
    end

    // ---- outputs: straight from stage p1 registers ----
    assign HPOS = h_p1;
    assign VPOS = v_p1;
    assign LOF  = lof_p1;
    assign HSTB = hstb_p1;
    assign VSTB = vstb_p1;
    assign VV   = {v_p1[7:0], h_p1[7:1]};
    assign LPH  = lph_p1;
    assign LPV  = lpv_p1;

endmodule

// File: tb/tb_beam_counter.sv
// ---------------------------------------------------------------------------
// tb_beam_counter
//
// Directed bench for beam_counter. Inputs change 1 ns after a rising edge,
// outputs are sampled at the same point, so each tick() shows the result of
// exactly one clock edge.
// ---------------------------------------------------------------------------
module tb_beam_counter;

    logic        CLK;
    logic        RST;
    logic        CE;
    logic        PAL;
    logic        LACE;
    logic        LP;
    logic        WR_VHPOS;
    logic        WR_VPOS;
    logic [15:0] DB;
    logic [7:0]  HPOS;
    logic [8:0]  VPOS;
    logic        LOF;
    logic        HSTB;
    logic        VSTB;
    logic [14:0] VV;
    logic [7:0]  LPH;
    logic [8:0]  LPV;

    int n_vec;
    int n_err;

    beam_counter dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .PAL      (PAL),
        .LACE     (LACE),
        .LP       (LP),
        .WR_VHPOS (WR_VHPOS),
        .WR_VPOS  (WR_VPOS),
        .DB       (DB),
        .HPOS     (HPOS),
        .VPOS     (VPOS),
        .LOF      (LOF),
        .HSTB     (HSTB),
        .VSTB     (VSTB),
        .VV       (VV),
        .LPH      (LPH),
        .LPV      (LPV)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_vhpos(input logic [15:0] d);
        CE       = 1'b0;
        WR_VHPOS = 1'b1;
        DB       = d;
        tick();
        WR_VHPOS = 1'b0;
    endtask

    task automatic wr_vpos(input logic [15:0] d);
        CE      = 1'b0;
        WR_VPOS = 1'b1;
        DB      = d;
        tick();
        WR_VPOS = 1'b0;
    endtask

    initial begin
        int nv;
        n_vec    = 0;
        n_err    = 0;
        RST      = 1'b1;
        CE       = 1'b0;
        PAL      = 1'b0;
        LACE     = 1'b0;
        LP       = 1'b0;
        WR_VHPOS = 1'b0;
        WR_VPOS  = 1'b0;
        DB       = 16'h0000;
        tick();
        tick();

        // Reset state
        chk("rst_hpos", HPOS, 0);
        chk("rst_vpos", VPOS, 0);
        chk("rst_lof",  LOF,  1);
        chk("rst_hstb", HSTB, 0);
        chk("rst_vstb", VSTB, 0);
        chk("rst_lph",  LPH,  0);
        chk("rst_lpv",  LPV,  0);
        chk("rst_vv",   VV,   0);
        RST = 1'b0;

        // Line wrap: H=225, V=10
        wr_vhpos(16'h0AE1);
        chk("lw_load_h", HPOS, 225);
        chk("lw_load_v", VPOS, 10);
        CE = 1'b1;
        tick();
        chk("lw_h226",   HPOS, 226);
        chk("lw_hstb0",  HSTB, 0);
        tick();
        chk("lw_h0",     HPOS, 0);
        chk("lw_v11",    VPOS, 11);
        chk("lw_hstb1",  HSTB, 1);
        chk("lw_vstb0",  VSTB, 0);
        CE = 1'b0;
        tick();
        chk("ce0_hold_h", HPOS, 0);
        chk("ce0_hstb",   HSTB, 0);

        // NTSC interlace: long frame wraps after 262, short after 261
        PAL  = 1'b0;
        LACE = 1'b1;
        wr_vpos(16'h8001);
        wr_vhpos(16'h06E2);
        chk("ntsc_load_v", VPOS, 262);
        CE = 1'b1;
        tick();
        CE = 1'b0;
        chk("ntsc_v0",    VPOS, 0);
        chk("ntsc_lof0",  LOF,  0);
        chk("ntsc_vstb",  VSTB, 1);
        chk("ntsc_hstb",  HSTB, 1);
        wr_vpos(16'h0001);
        wr_vhpos(16'h05E2);
        CE = 1'b1;
        tick();
        CE = 1'b0;
        chk("ntsc_s_v0",   VPOS, 0);
        chk("ntsc_s_lof1", LOF,  1);
        chk("ntsc_s_vstb", VSTB, 1);

        // PAL non-interlace: short frame wraps after 311, then one full long frame
        PAL  = 1'b1;
        LACE = 1'b0;
        wr_vpos(16'h0001);
        wr_vhpos(16'h37E2);
        chk("pal_load_v", VPOS, 311);
        CE = 1'b1;
        tick();
        chk("pal_v0",   VPOS, 0);
        chk("pal_lof1", LOF,  1);
        chk("pal_vstb", VSTB, 1);
        nv = 0;
        for (int i = 0; i < 313 * 227; i++) begin
            tick();
            if (VSTB) nv++;
        end
        CE = 1'b0;
        chk("pal_frame_vstb", nv, 1);
        chk("pal_frame_h",    HPOS, 0);
        chk("pal_frame_v",    VPOS, 0);
        chk("pal_frame_lof",  LOF,  1);

        // Write priority over counting
        wr_vhpos(16'h00E2);
        CE       = 1'b1;
        WR_VHPOS = 1'b1;
        DB       = 16'h2C40;
        tick();
        WR_VHPOS = 1'b0;
        chk("wp_h",    HPOS, 8'h40);
        chk("wp_v",    VPOS, 9'h02C);
        chk("wp_hstb", HSTB, 0);
        chk("wp_vstb", VSTB, 0);
        WR_VPOS = 1'b1;
        DB      = 16'h8001;
        tick();
        WR_VPOS = 1'b0;
        chk("wp_lof",  LOF,  1);
        chk("wp_v8",   VPOS, 9'h12C);
        chk("wp_hold", HPOS, 8'h40);
        chk("wp_vv",   VV,   15'h1620);
        tick();
        CE = 1'b0;
        chk("wp_resume", HPOS, 8'h41);

        // Simultaneous writes: DB=0x0105 -> H=5, V[7:0]=1, V[8]=1, LOF=0
        CE       = 1'b0;
        WR_VHPOS = 1'b1;
        WR_VPOS  = 1'b1;
        DB       = 16'h0105;
        tick();
        WR_VHPOS = 1'b0;
        WR_VPOS  = 1'b0;
        chk("both_h",   HPOS, 5);
        chk("both_v",   VPOS, 9'h101);
        chk("both_lof", LOF,  0);

        // H written above 226 counts to 255 then wraps
        wr_vpos(16'h8000);
        wr_vhpos(16'h05FA);
        CE = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("hbig_255",  HPOS, 255);
        chk("hbig_hs0",  HSTB, 0);
        tick();
        CE = 1'b0;
        chk("hbig_h0",   HPOS, 0);
        chk("hbig_v6",   VPOS, 6);
        chk("hbig_hs1",  HSTB, 1);

        // Light pen: first edge captures H=100, V=50
        PAL  = 1'b0;
        LACE = 1'b1;
        wr_vpos(16'h0000);
        wr_vhpos(16'h3264);
        LP = 1'b1;
        tick();
        chk("lp_delay", LPH, 0);
        tick();
        chk("lp1_h", LPH, 100);
        chk("lp1_v", LPV, 50);
        LP = 1'b0;
        tick();
        tick();
        wr_vhpos(16'h3C78);
        LP = 1'b1;
        tick();
        tick();
        chk("lp2_h", LPH, 100);
        chk("lp2_v", LPV, 50);

        // Edge coinciding with a V=511 wrap while disarmed: no capture, re-armed
        LP = 1'b0;
        tick();
        tick();
        wr_vpos(16'h0001);
        wr_vhpos(16'hFFE2);
        LP = 1'b1;
        tick();
        CE = 1'b1;
        tick();
        CE = 1'b0;
        chk("v511_v0",   VPOS, 0);
        chk("v511_vstb", VSTB, 1);
        chk("v511_lof",  LOF,  1);
        chk("v511_lph",  LPH,  100);
        LP = 1'b0;
        tick();
        tick();
        wr_vhpos(16'h0305);
        LP = 1'b1;
        tick();
        tick();
        chk("lp3_h", LPH, 5);
        chk("lp3_v", LPV, 3);

        // Re-arm by a plain wrap, then edge and wrap together while armed
        LP = 1'b0;
        tick();
        tick();
        wr_vpos(16'h0001);
        wr_vhpos(16'hFFE2);
        CE = 1'b1;
        tick();
        CE = 1'b0;
        wr_vpos(16'h0001);
        wr_vhpos(16'hFFE2);
        LP = 1'b1;
        tick();
        CE = 1'b1;
        tick();
        CE = 1'b0;
        chk("lpw_h",    LPH,  8'hE2);
        chk("lpw_v",    LPV,  9'h1FF);
        chk("lpw_vpos", VPOS, 0);
        LP = 1'b0;
        tick();
        tick();
        wr_vhpos(16'h0907);
        LP = 1'b1;
        tick();
        tick();
        LP = 1'b0;
        chk("lpw_rearm_h", LPH, 7);
        chk("lpw_rearm_v", LPV, 9);

        // Reset mid-frame with CE, write and LP active
        wr_vpos(16'h0000);
        wr_vhpos(16'hC84F);
        CE = 1'b1;
        tick();
        chk("mr_h80", HPOS, 80);
        RST      = 1'b1;
        WR_VHPOS = 1'b1;
        DB       = 16'h1234;
        LP       = 1'b1;
        tick();
        chk("mr_h",    HPOS, 0);
        chk("mr_v",    VPOS, 0);
        chk("mr_lof",  LOF,  1);
        chk("mr_hstb", HSTB, 0);
        chk("mr_vstb", VSTB, 0);
        chk("mr_lph",  LPH,  0);
        chk("mr_lpv",  LPV,  0);
        chk("mr_vv",   VV,   0);
        RST      = 1'b0;
        WR_VHPOS = 1'b0;
        CE       = 1'b0;
        LP       = 1'b0;
        tick();
        chk("mr_idle_h", HPOS, 0);
        CE = 1'b1;
        tick();
        CE = 1'b0;
        chk("mr_run_h", HPOS, 1);
        chk("mr_run_v", VPOS, 0);

        // Reset at H=226 with CE: no line strobe
        wr_vhpos(16'h00E2);
        CE  = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        CE  = 1'b0;
        chk("rw_hstb", HSTB, 0);
        chk("rw_h",    HPOS, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/beam_counter.md
BEAM_COUNTER -- requirements
Module: beam_counter

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port CE, input, 1, colour-clock enable; beam advances only in cycles with CE=1.
REQ-004 SHALL have port PAL, input, 1, line standard: 1=PAL (313/312 lines), 0=NTSC (263/262 lines).
REQ-005 SHALL have port LACE, input, 1, interlace enable; controls the LOF toggle.
REQ-006 SHALL have port LP, input, 1, light-pen strobe; level input, rising edge significant.
REQ-007 SHALL have port WR_VHPOS, input, 1, write strobe: load V[7:0]/H[7:0] from DB.
REQ-008 SHALL have port WR_VPOS, input, 1, write strobe: load LOF/V[8] from DB.
REQ-009 SHALL have port DB, input, 16, data bus for writes.
REQ-010 SHALL have port HPOS, output, 8, horizontal beam position, 0..226.
REQ-011 SHALL have port VPOS, output, 9, vertical beam position.
REQ-012 SHALL have port LOF, output, 1, long-frame flag.
REQ-013 SHALL have port HSTB, output, 1, one-cycle pulse on line wrap.
REQ-014 SHALL have port VSTB, output, 1, one-cycle pulse on frame wrap.
REQ-015 SHALL have port VV, output, 15, compare bus to the copper comparator slices = {VPOS[7:0], HPOS[7:1]}.
REQ-016 SHALL have port LPH, output, 8, light-pen horizontal latch.
REQ-017 SHALL have port LPV, output, 9, light-pen vertical latch.

Function
REQ-018 SHALL register all outputs; VV SHALL be a pure bit selection of the registered HPOS/VPOS.
REQ-019 In a CE=1 cycle with no write: if H=226, H SHALL go to 0 and V SHALL advance; otherwise H SHALL go to H+1.
REQ-020 The last line SHALL be: PAL: 312 if LOF=1, else 311; NTSC: 262 if LOF=1, else 261.
REQ-021 V advance: if V=last line, V SHALL go to 0 (frame wrap); otherwise V SHALL go to V+1.
REQ-022 If V exceeds last line (after a write or a PAL change), V SHALL keep incrementing and wrap modulo 512 to 0; that wrap SHALL count as a frame wrap.
REQ-023 On frame wrap, LOF SHALL become ~LOF if LACE=1, and 1 if LACE=0.
REQ-024 HSTB SHALL be 1 in the cycle after each H wrap and 0 otherwise.
REQ-025 VSTB SHALL be 1 in the cycle after each frame wrap and 0 otherwise; when both occur, HSTB and VSTB SHALL pulse together.
REQ-026 With CE=0, H/V/LOF SHALL hold, and HSTB/VSTB SHALL be 0.
REQ-027 WR_VHPOS SHALL load H<=DB[7:0] and V[7:0]<=DB[15:8].
REQ-028 WR_VPOS SHALL load LOF<=DB[15] and V[8]<=DB[0].
REQ-029 Writes SHALL take priority over counting in the same cycle.
REQ-030 A write SHALL produce no HSTB/VSTB.
REQ-031 Simultaneous WR_VHPOS and WR_VPOS SHALL apply both loads.
REQ-032 A written H>226 SHALL count up to 255, then wrap to 0 as a normal line wrap.
REQ-033 LP SHALL be registered once, and rising-edge detected against its previous registered value.
REQ-034 On an LP rising edge while armed, LPH/LPV SHALL capture the current H/V and the block SHALL disarm.
REQ-035 The block SHALL re-arm on frame wrap; if an LP edge and a frame wrap occur in the same cycle, the capture SHALL use the pre-wrap H/V and the block SHALL end armed.

Reset
REQ-036 RST SHALL take priority over CE, writes and LP.
REQ-037 On RST, the block SHALL set H=0, V=0, LOF=1, HSTB=0, VSTB=0, LPH=0, LPV=0, armed=1, and the LP history register to 0.
REQ-038 RST asserted mid-line or mid-frame SHALL abort the line/frame with no strobe; counting SHALL resume from 0,0 at the first CE after RST is released.

Verification
REQ-039 Line wrap: RST; write H=225, V=10; two CE cycles -> HPOS 226 then 0, VPOS=11, HSTB pulses once, VSTB=0.
REQ-040 NTSC interlace: PAL=0, LACE=1, LOF=1, V=262, H=226, one CE -> V=0, LOF=0, VSTB=1; next frame wraps after line 261 -> LOF=1.
REQ-041 PAL non-interlace: PAL=1, LACE=0, LOF=0, V=311, H=226, one CE -> V=0, LOF=1; then a full frame of 313*227 CE cycles produces exactly one VSTB.
REQ-042 Write priority: CE=1 with WR_VHPOS, DB=0x2C40 in the same cycle -> H=0x40, V=0x2C, no strobe; WR_VPOS with DB=0x8001 -> LOF=1, V=0x12C.
REQ-043 Light pen: LP edge at H=100, V=50 -> LPH=100, LPV=50; second edge in the same frame -> latches unchanged; after frame wrap, an edge at H=5, V=3 -> LPH=5, LPV=3.
REQ-044 Reset mid-frame: counting at H=80, V=200, assert RST with CE=1 and WR_VHPOS -> all outputs at reset values, no strobe; VV=0.
